// File: rtl/sig_filt_mc.sv
// sig_filt_mc: per-channel three-flop synchroniser, stability-counter debounce and edge pulses.
// Period measurement is compiled in only when macro SIG_FILT_PERIOD_EN is defined.
module sig_filt_mc #(
  parameter int NCH      = 4,
  parameter int STBL_W   = 16,
  parameter int FAST_SIM = 1,
  parameter int PER_W    = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       sig_in,
  output logic [NCH-1:0]       sig_filt,
  output logic [NCH-1:0]       sig_rise,
  output logic [NCH-1:0]       sig_fall,
  output logic [NCH-1:0]       per_vld,
  output logic [NCH*PER_W-1:0] period,
  output logic [NCH-1:0]       timeout
);

  localparam logic [STBL_W-1:0] THRESH = (FAST_SIM != 0) ? STBL_W'(511) : {STBL_W{1'b1}};

  logic [NCH-1:0]             ff1_q, ff2_q, ff3_q;
  logic [NCH-1:0]             filt_q, filt_d, prev_q;
  logic [NCH-1:0][STBL_W-1:0] stbl_q, stbl_d;
  logic [NCH-1:0]             rise_s, fall_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= '0;
      ff2_q <= '0;
      ff3_q <= '0;
    end else begin
      ff1_q <= sig_in;
      ff2_q <= ff1_q;
      ff3_q <= ff2_q;
    end
  end

  // The filtered level only follows ff3 once the counter has seen THRESH quiet cycles.
  always_comb begin
    stbl_d = stbl_q;
    filt_d = filt_q;
    for (int i = 0; i < NCH; i++) begin
      if (ff2_q[i] != ff3_q[i]) begin
        stbl_d[i] = '0;
      end else if (stbl_q[i] < THRESH) begin
        stbl_d[i] = stbl_q[i] + STBL_W'(1);
      end else begin
        stbl_d[i] = stbl_q[i];
      end
      if (stbl_q[i] >= THRESH) begin
        filt_d[i] = ff3_q[i];
      end else begin
        filt_d[i] = filt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stbl_q <= '0;
      filt_q <= '0;
      prev_q <= '0;
    end else begin
      stbl_q <= stbl_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
    end
  end

  assign rise_s   = filt_q & ~prev_q;
  assign fall_s   = ~filt_q & prev_q;
  assign sig_filt = filt_q;
  assign sig_rise = rise_s;
  assign sig_fall = fall_s;

`ifdef SIG_FILT_PERIOD_EN
  localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

  logic [NCH-1:0][PER_W-1:0] pcnt_q, pcnt_d, per_q, per_d;
  logic [NCH-1:0]            arm_q, arm_d, vld_q, vld_d;

  // Restarting at 1 on the rise cycle makes rises N cycles apart read back as N.
  always_comb begin
    pcnt_d = pcnt_q;
    per_d  = per_q;
    arm_d  = arm_q;
    vld_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rise_s[i]) begin
        pcnt_d[i] = PER_W'(1);
        arm_d[i]  = 1'b1;
        if (arm_q[i] && (pcnt_q[i] != PER_MAX)) begin
          per_d[i] = pcnt_q[i];
          vld_d[i] = 1'b1;
        end else begin
          per_d[i] = per_q[i];
          vld_d[i] = 1'b0;
        end
      end else if (pcnt_q[i] != PER_MAX) begin
        pcnt_d[i] = pcnt_q[i] + PER_W'(1);
      end else begin
        pcnt_d[i] = pcnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      per_q  <= '0;
      arm_q  <= '0;
      vld_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      per_q  <= per_d;
      arm_q  <= arm_d;
      vld_q  <= vld_d;
    end
  end

  always_comb begin
    period  = '0;
    timeout = '0;
    for (int i = 0; i < NCH; i++) begin
      period[i*PER_W +: PER_W] = per_q[i];
      timeout[i]               = (pcnt_q[i] == PER_MAX);
    end
  end

  assign per_vld = vld_q;
`else
  assign per_vld = '0;
  assign period  = '0;
  assign timeout = '0;
`endif

endmodule

// File: tb/tb_sig_filt_mc.sv
// Scoreboard bench for sig_filt_mc: a window-based reference model queues expected pulses,
// a monitor pops and compares them against the DUT each cycle.
module tb_sig_filt_mc;
  localparam int NCH   = 4;
  localparam int PER_W = 12;
  localparam int PMAX  = 4095;
  localparam int WIN   = 512;
  localparam int MAXE  = 65536;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       sig_in = '0;
  logic [NCH-1:0]       sig_filt, sig_rise, sig_fall, per_vld, timeout;
  logic [NCH*PER_W-1:0] period;

  sig_filt_mc #(.NCH(NCH), .STBL_W(16), .FAST_SIM(1), .PER_W(PER_W)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sig_filt(sig_filt), .sig_rise(sig_rise),
    .sig_fall(sig_fall), .per_vld(per_vld), .period(period), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int kind; int cyc; int per;} ev_t;  // kind: 0 rise, 1 fall, 2 per_vld
  ev_t sbq[$];

  int checks = 0;
  int errors = 0;
  int ecyc = 0;
  bit samp [NCH][0:MAXE+2];
  int lc   [NCH][0:MAXE+2];
  bit mfilt [NCH];
  int tref  [NCH];
  bit armed [NCH];
  bit pend  [NCH];
  int pend_per [NCH];
  int nrise [NCH];
  int nfall [NCH];
  int nvld  [NCH];
  int rise_cyc [NCH];
  int fall_cyc [NCH];
  int last_per [NCH];

  // Reference model: the level follows the input sample three edges back once the
  // last WIN samples up to it are all equal (and WIN edges have elapsed since reset).
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        ecyc = 0;
        for (int c = 0; c < NCH; c++) begin
          for (int k = 0; k < 3; k++) begin
            samp[c][k] = 1'b0;
            lc[c][k]   = -100000;
          end
          mfilt[c] = 1'b0; tref[c] = 0; armed[c] = 1'b0; pend[c] = 1'b0;
        end
      end else begin
        ecyc++;
        if (ecyc > MAXE) begin
          $display("FAIL model_range cycle=%0d limit=%0d", ecyc, MAXE);
          $fatal(1, "model history exhausted");
        end
        for (int c = 0; c < NCH; c++) begin
          if (pend[c]) begin
`ifdef SIG_FILT_PERIOD_EN
            sbq.push_back('{ch: c, kind: 2, cyc: ecyc, per: pend_per[c]});
`endif
            pend[c] = 1'b0;
          end
        end
        for (int c = 0; c < NCH; c++) begin
          int idx;
          bit nv;
          idx = ecyc + 2;
          samp[c][idx] = sig_in[c];
          lc[c][idx] = (samp[c][idx] != samp[c][idx-1]) ? ecyc : lc[c][idx-1];
          if (ecyc >= WIN && lc[c][idx-3] <= ecyc - 514) begin
            nv = samp[c][idx-3];
            if (nv != mfilt[c]) begin
              sbq.push_back('{ch: c, kind: (nv ? 0 : 1), cyc: ecyc, per: 0});
              if (nv) begin
                if (armed[c] && (ecyc - tref[c]) < PMAX) begin
                  pend[c] = 1'b1;
                  pend_per[c] = ecyc - tref[c];
                end
                armed[c] = 1'b1;
                tref[c] = ecyc;
              end
              mfilt[c] = nv;
            end
          end
        end
      end
    end
  end

  task automatic pop_check(input int ch, input int kind, input int per);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse ch=%0d kind=%0d cycle=%0d got pulse, expected none", ch, kind, ecyc);
    end else begin
      e = sbq.pop_front();
      if (e.ch != ch || e.kind != kind || e.cyc != ecyc || (kind == 2 && e.per != per)) begin
        errors++;
        $display("FAIL pulse_match got ch=%0d kind=%0d cyc=%0d per=%0d expected ch=%0d kind=%0d cyc=%0d per=%0d",
                 ch, kind, ecyc, per, e.ch, e.kind, e.cyc, e.per);
      end
    end
  endtask

  // Monitor: consumes DUT pulses and compares levels away from the active edge.
  initial begin
    forever begin
      logic [NCH-1:0] exp_filt, exp_to;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (per_vld[c]) begin
          pop_check(c, 2, int'(period[c*PER_W +: PER_W]));
          nvld[c]++;
          last_per[c] = int'(period[c*PER_W +: PER_W]);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (sig_rise[c]) begin pop_check(c, 0, 0); nrise[c]++; rise_cyc[c] = ecyc; end
        if (sig_fall[c]) begin pop_check(c, 1, 0); nfall[c]++; fall_cyc[c] = ecyc; end
      end
      while (sbq.size() > 0 && sbq[0].cyc <= ecyc) begin
        checks++; errors++;
        $display("FAIL missed_pulse ch=%0d kind=%0d expected at cycle %0d, no pulse observed through cycle %0d",
                 sbq[0].ch, sbq[0].kind, sbq[0].cyc, ecyc);
        void'(sbq.pop_front());
      end
      for (int c = 0; c < NCH; c++) begin
        exp_filt[c] = mfilt[c];
        exp_to[c]   = ((ecyc - tref[c]) >= PMAX);
      end
      checks++;
      if (sig_filt !== exp_filt) begin
        errors++;
        $display("FAIL filt_level cycle=%0d got %b expected %b", ecyc, sig_filt, exp_filt);
      end
      checks++;
`ifdef SIG_FILT_PERIOD_EN
      if (timeout !== exp_to) begin
        errors++;
        $display("FAIL timeout_level cycle=%0d got %b expected %b", ecyc, timeout, exp_to);
      end
`else
      if (timeout !== '0 || per_vld !== '0 || period !== '0) begin
        errors++;
        $display("FAIL period_tied cycle=%0d got to=%b vld=%b per=%h expected zeros",
                 ecyc, timeout, per_vld, period);
      end
`endif
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int e0;
    int snap_r [NCH];
    int snap_f;
    int snap_v;
    int hold [NCH];

    for (int c = 0; c < NCH; c++) begin
      nrise[c] = 0; nfall[c] = 0; nvld[c] = 0; rise_cyc[c] = 0; fall_cyc[c] = 0; last_per[c] = 0;
    end
    wait_cyc(3);
    check_int("reset_outputs_zero", int'({sig_filt, sig_rise, sig_fall, per_vld, timeout} != '0 || period != '0), 0);
    rst_n = 1'b1;
    wait_cyc(600);

    // Clean step on ch0: one rise, 515 edges after the first sampling edge.
    for (int c = 0; c < NCH; c++) snap_r[c] = nrise[c];
    sig_in[0] = 1'b1; e0 = ecyc;
    wait_cyc(600);
    check_int("ch0_step_latency", rise_cyc[0] - e0, 515);
    check_int("ch0_rise_count", nrise[0] - snap_r[0], 1);
    check_int("others_quiet", (nrise[1] - snap_r[1]) + (nrise[2] - snap_r[2]) + (nrise[3] - snap_r[3]), 0);

    // 300-cycle pulse on ch1 is rejected.
    snap_f = nfall[1];
    sig_in[1] = 1'b1; wait_cyc(300); sig_in[1] = 1'b0; wait_cyc(600);
    check_int("ch1_glitch_level", int'(sig_filt[1]), 0);
    check_int("ch1_glitch_edges", (nrise[1] - snap_r[1]) + (nfall[1] - snap_f), 0);

    // Stable high then low on ch3: one fall, 515 edges after the step.
    sig_in[3] = 1'b1; wait_cyc(600);
    snap_f = nfall[3];
    sig_in[3] = 1'b0; e0 = ecyc; wait_cyc(600);
    check_int("ch3_fall_latency", fall_cyc[3] - e0, 515);
    check_int("ch3_fall_count", nfall[3] - snap_f, 1);

    // Square wave on ch2, 2000-cycle period, three rises.
    snap_v = nvld[2];
    for (int k = 0; k < 3; k++) begin
      sig_in[2] = 1'b1; wait_cyc(1000);
      sig_in[2] = 1'b0; wait_cyc(1000);
    end
`ifdef SIG_FILT_PERIOD_EN
    check_int("ch2_per_vld_count", nvld[2] - snap_v, 2);
    check_int("ch2_period", last_per[2], 2000);
`else
    check_int("ch2_per_vld_count", nvld[2] - snap_v, 0);
`endif

    // Long silence on ch0 saturates its period counter; next rise clears timeout, no per_vld.
    sig_in[0] = 1'b0; wait_cyc(600);
`ifdef SIG_FILT_PERIOD_EN
    check_int("ch0_timeout_set", int'(timeout[0]), 1);
`endif
    snap_v = nvld[0];
    sig_in[0] = 1'b1; wait_cyc(600);
    check_int("ch0_timeout_clear", int'(timeout[0]), 0);
    check_int("ch0_no_vld_after_timeout", nvld[0] - snap_v, 0);

    // Random phase: mix of glitches and long holds on all channels.
    for (int c = 0; c < NCH; c++) hold[c] = $urandom_range(1, 1200);
    for (int t = 0; t < 8000; t++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          sig_in[c] = ~sig_in[c];
          hold[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 400) : $urandom_range(520, 1500);
        end
      end
    end

    // Reset mid-operation with ch0 filtered high: immediate zeros, no fall afterwards.
    sig_in = 4'b0001; wait_cyc(600);
    check_int("pre_reset_filt", int'(sig_filt[0]), 1);
    #2 rst_n = 1'b0;
    #1 check_int("async_reset_zero", int'({sig_filt, sig_rise, sig_fall, per_vld, timeout} != '0 || period != '0), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    snap_f = nfall[0];
    wait_cyc(600);
    check_int("no_fall_after_reset", nfall[0] - snap_f, 0);
    check_int("refilter_after_reset", int'(sig_filt[0]), 1);

    wait_cyc(2);
    check_int("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
